// File: rtl/fa4_serial_add_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fa4_pkg: definitions shared by the nibble-serial adder controller.
//   NIBBLE_W : width of one adder slice (4 bits)
//   state_e  : controller states ST_IDLE / ST_RUN / ST_DONE
// Optional build macro used by the files that import this package:
//   FA4_SERIAL_SUB_EN adds a subtract mode.
// -----------------------------------------------------------------------------
package fa4_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fa4_serial_add_ctrl_if.sv
// -----------------------------------------------------------------------------
// fa4_serial_add_ctrl_if: start/busy/done bundle of the nibble-serial adder.
//   start, a, b, cin, (sub) : request from the iteration FSM
//   busy, done, s, cout, ovf: status and registered result from the adder
// Modports: master = requester (iteration FSM), slave = adder controller.
// Build macro FA4_SERIAL_SUB_EN adds the 1-bit sub request signal.
// -----------------------------------------------------------------------------
interface fa4_serial_add_ctrl_if #(
    parameter int DATA_WIDTH = 24
);
    logic                  start;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  cin;
`ifdef FA4_SERIAL_SUB_EN
    logic                  sub;
`endif
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] s;
    logic                  cout;
    logic                  ovf;

`ifdef FA4_SERIAL_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, s, cout, ovf);
    modport slave  (input start, a, b, cin, sub, output busy, done, s, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, s, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, s, cout, ovf);
`endif

endinterface

// File: rtl/fa4_serial_add_ctrl_fa4.sv
// -----------------------------------------------------------------------------
// FA_4: 4-bit full-adder slice, purely combinational.
//   a, b : 4-bit addends    cin  : carry in
//   s    : 4-bit sum        cout : carry out
// -----------------------------------------------------------------------------
module FA_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/fa4_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// fa4_serial_add_ctrl: nibble-serial wide adder. One FA_4 slice is stepped
// over a DATA_WIDTH operand, least-significant nibble first, with the carry
// held in a register between cycles. DATA_WIDTH must be a multiple of 4 and
// at least 8; the operation takes NIBBLES = DATA_WIDTH/4 RUN cycles.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset (discards any operation in flight)
//   bus   : slave side of fa4_serial_add_ctrl_if
//           start/a/b/cin(/sub) sampled on the accept edge in IDLE,
//           busy high in RUN and DONE, done a one-cycle result strobe,
//           s/cout/ovf registered and held until the next accept.
// Build macro FA4_SERIAL_SUB_EN: sub=1 computes a-b (b inverted, carry-in 1).
// -----------------------------------------------------------------------------
module fa4_serial_add_ctrl
    import fa4_pkg::*;
#(
    parameter int DATA_WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fa4_serial_add_ctrl_if.slave    bus
);

    localparam int NIBBLES = DATA_WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int MSB     = DATA_WIDTH - 1;

    state_e                  state, state_nxt;
    logic                    accept;
    logic                    last;

    logic [DATA_WIDTH-1:0]   a_reg, b_reg, s_reg;
    logic                    carry, cout_reg, ovf_reg;
    logic [IDX_W-1:0]        idx;

    logic [DATA_WIDTH-1:0]   b_eff;
    logic                    cin_eff;

    logic [NIBBLE_W-1:0]     nib_a, nib_b, nib_s;
    logic                    nib_c;

    // Subtraction is a + ~b + 1, folded into the operands at accept so the
    // RUN path is identical for both modes.
`ifdef FA4_SERIAL_SUB_EN
    assign b_eff   = bus.sub ? ~bus.b : bus.b;
    assign cin_eff = bus.sub ? 1'b1   : bus.cin;
`else
    assign b_eff   = bus.b;
    assign cin_eff = bus.cin;
`endif

    assign last  = (idx == IDX_W'(NIBBLES - 1));
    assign nib_a = a_reg[NIBBLE_W*idx +: NIBBLE_W];
    assign nib_b = b_reg[NIBBLE_W*idx +: NIBBLE_W];

    FA_4 u_fa4 (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry),
        .s    (nib_s),
        .cout (nib_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN:  if (last) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            s_reg    <= '0;
            carry    <= 1'b0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
            idx      <= '0;
        end else if (accept) begin
            a_reg <= bus.a;
            b_reg <= b_eff;
            carry <= cin_eff;
            idx   <= '0;
            s_reg <= '0;
        end else if (state == ST_RUN) begin
            s_reg[NIBBLE_W*idx +: NIBBLE_W] <= nib_s;
            carry <= nib_c;
            idx   <= idx + 1'b1;
            if (last) begin
                cout_reg <= nib_c;
                // Overflow: like-signed operands whose sum sign differs.
                ovf_reg  <= (a_reg[MSB] == b_reg[MSB]) &&
                            (nib_s[NIBBLE_W-1] != a_reg[MSB]);
            end
        end
    end

    assign bus.busy = (state != ST_IDLE);
    assign bus.done = (state == ST_DONE);
    assign bus.s    = s_reg;
    assign bus.cout = cout_reg;
    assign bus.ovf  = ovf_reg;

endmodule
